// File: rtl/gcd_pkg.sv
// Shared types for the GCD engine: FSM state encoding and its width.
package gcd_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE_A = 3'd0,
    ACK_A  = 3'd1,
    IDLE_B = 3'd2,
    CALC   = 3'd3,
    DONE   = 3'd4
  } gcd_state_e;

endpackage

// File: rtl/gcd_engine_if.sv
// Four-phase req/ack operand/result bus of the GCD engine.
// iter_count is present only when GCD_ITER_COUNT_EN is defined.
interface gcd_engine_if #(
  parameter int unsigned WIDTH = 8
);

  logic             req;
  logic [WIDTH-1:0] data_in;
  logic             ack;
  logic             busy;
  logic [WIDTH-1:0] result;
`ifdef GCD_ITER_COUNT_EN
  logic [WIDTH-1:0] iter_count;
`endif

  modport master (
    output req,
    output data_in,
    input  ack,
    input  busy,
`ifdef GCD_ITER_COUNT_EN
    input  iter_count,
`endif
    input  result
  );

  modport slave (
    input  req,
    input  data_in,
    output ack,
    output busy,
`ifdef GCD_ITER_COUNT_EN
    output iter_count,
`endif
    output result
  );

endinterface

// File: rtl/gcd_datapath.sv
// Operand registers A/B with a single shared subtractor and the comparator flags.
module gcd_datapath #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_a_i,
  input  logic             load_b_i,
  input  logic             sub_en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             a_zero_o,
  output logic             b_zero_o,
  output logic             eq_o,
  output logic             a_gt_b_o
);

  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] minuend_c, subtrahend_c, diff_c;

  assign a_zero_o = (a_q == '0);
  assign b_zero_o = (b_q == '0);
  assign eq_o     = (a_q == b_q);
  assign a_gt_b_o = (a_q > b_q);

  // Larger operand always minuend, so the difference never wraps.
  assign minuend_c    = a_gt_b_o ? a_q : b_q;
  assign subtrahend_c = a_gt_b_o ? b_q : a_q;
  assign diff_c       = minuend_c - subtrahend_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (load_a_i) begin
        a_q <= data_i;
      end else if (sub_en_i && a_gt_b_o) begin
        a_q <= diff_c;
      end
      if (load_b_i) begin
        b_q <= data_i;
      end else if (sub_en_i && !a_gt_b_o) begin
        b_q <= diff_c;
      end
    end
  end

  assign a_o = a_q;
  assign b_o = b_q;

endmodule

// File: rtl/gcd_engine.sv
// GCD by repeated subtraction behind a four-phase req/ack handshake.
// Optional saturating subtraction counter enabled by GCD_ITER_COUNT_EN.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  gcd_engine_if.slave bus
);

  gcd_state_e       state_q, state_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             load_a_c, load_b_c, sub_en_c, term_c;
  logic [WIDTH-1:0] a_c, b_c;
  logic             a_zero_c, b_zero_c, eq_c, a_gt_b_c;

  gcd_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .reset    (reset),
    .load_a_i (load_a_c),
    .load_b_i (load_b_c),
    .sub_en_i (sub_en_c),
    .data_i   (bus.data_in),
    .a_o      (a_c),
    .b_o      (b_c),
    .a_zero_o (a_zero_c),
    .b_zero_o (b_zero_c),
    .eq_o     (eq_c),
    .a_gt_b_o (a_gt_b_c)
  );

  assign term_c = a_zero_c || b_zero_c || eq_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE_A;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE_A:  if (bus.req)  state_d = ACK_A;
      ACK_A:   if (!bus.req) state_d = IDLE_B;
      IDLE_B:  if (bus.req)  state_d = CALC;
      CALC:    if (term_c)   state_d = DONE;
      DONE:    if (!bus.req) state_d = IDLE_A;
      default: state_d = IDLE_A;
    endcase
  end

  // req is deliberately not looked at in CALC.
  always_comb begin
    ack_d    = ack_q;
    busy_d   = busy_q;
    result_d = result_q;
    load_a_c = 1'b0;
    load_b_c = 1'b0;
    sub_en_c = 1'b0;
    unique case (state_q)
      IDLE_A: if (bus.req) begin
        load_a_c = 1'b1;
        ack_d    = 1'b1;
      end
      ACK_A: if (!bus.req) ack_d = 1'b0;
      IDLE_B: if (bus.req) begin
        load_b_c = 1'b1;
        busy_d   = 1'b1;
      end
      CALC: if (term_c) begin
        result_d = a_zero_c ? b_c : a_c;
        ack_d    = 1'b1;
        busy_d   = 1'b0;
      end else begin
        sub_en_c = 1'b1;
      end
      DONE: if (!bus.req) ack_d = 1'b0;
      default: ;
    endcase
  end

  assign bus.ack    = ack_q;
  assign bus.busy   = busy_q;
  assign bus.result = result_q;

`ifdef GCD_ITER_COUNT_EN
  logic [WIDTH-1:0] cnt_q;

  // Cleared on the B-load edge, saturates at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == IDLE_B && bus.req) begin
      cnt_q <= '0;
    end else if (sub_en_c && cnt_q != '1) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign bus.iter_count = cnt_q;
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// Directed self-checking bench for gcd_engine (WIDTH=8).
module tb_gcd_engine;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  gcd_engine_if #(.WIDTH(WIDTH)) bus ();

  gcd_engine #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp_res;
    int               exp_k;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [WIDTH-1:0] a);
    bus.req     = 1'b1;
    bus.data_in = a;
    tick();
    check("ack_after_a", 32'(bus.ack), 32'd1);
    bus.req = 1'b0;
    tick();
    check("ack_drop_a", 32'(bus.ack), 32'd0);
  endtask

  task automatic load_b(input logic [WIDTH-1:0] b);
    bus.req     = 1'b1;
    bus.data_in = b;
    tick();
    check("busy_after_b", 32'(bus.busy), 32'd1);
  endtask

  // Latency counts edges after the B-load edge until ack rises.
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = 1;
    while (bus.ack !== 1'b1 && lat < 400) begin
      tick();
      lat++;
      if (bus.ack !== 1'b1 && bus.busy === 1'b1) busy_n++;
    end
  endtask

  task automatic end_txn();
    bus.req = 1'b0;
    tick();
    check("ack_drop_done", 32'(bus.ack), 32'd0);
  endtask

  initial begin
    int lat, busy_n;
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b1;
    bus.req     = 1'b0;
    bus.data_in = '0;

    vecs[0] = '{a: 8'd12,  b: 8'd18,  exp_res: 8'd6,   exp_k: 2};
    vecs[1] = '{a: 8'd7,   b: 8'd0,   exp_res: 8'd7,   exp_k: 0};
    vecs[2] = '{a: 8'd0,   b: 8'd0,   exp_res: 8'd0,   exp_k: 0};
    vecs[3] = '{a: 8'd255, b: 8'd1,   exp_res: 8'd1,   exp_k: 254};
    vecs[4] = '{a: 8'd9,   b: 8'd6,   exp_res: 8'd3,   exp_k: 2};
    vecs[5] = '{a: 8'd0,   b: 8'd5,   exp_res: 8'd5,   exp_k: 0};
    vecs[6] = '{a: 8'd4,   b: 8'd6,   exp_res: 8'd2,   exp_k: 2};
    vecs[7] = '{a: 8'd200, b: 8'd200, exp_res: 8'd200, exp_k: 0};
    vecs[8] = '{a: 8'd17,  b: 8'd5,   exp_res: 8'd1,   exp_k: 6};

    repeat (3) tick();
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      load_a(vecs[i].a);
      load_b(vecs[i].b);
      wait_done(lat, busy_n);
      check($sformatf("latency_v%0d", i), 32'(lat), 32'(vecs[i].exp_k + 1));
      check($sformatf("busy_cycles_v%0d", i), 32'(busy_n), 32'(vecs[i].exp_k + 1));
      check($sformatf("busy_low_v%0d", i), 32'(bus.busy), 32'd0);
      check($sformatf("result_v%0d", i), 32'(bus.result), 32'(vecs[i].exp_res));
`ifdef GCD_ITER_COUNT_EN
      check($sformatf("iter_v%0d", i), 32'(bus.iter_count), 32'(vecs[i].exp_k));
`endif
      end_txn();
    end

    // Stall in ACK_A and DONE with data_in changing; no extra load may happen.
    bus.req     = 1'b1;
    bus.data_in = 8'd20;
    tick();
    check("stall_ack_a", 32'(bus.ack), 32'd1);
    repeat (5) begin
      bus.data_in = 8'd99;
      tick();
      check("stall_ack_a_hold", 32'(bus.ack), 32'd1);
    end
    bus.req = 1'b0;
    tick();
    check("stall_ack_a_drop", 32'(bus.ack), 32'd0);
    load_b(8'd8);
    wait_done(lat, busy_n);
    check("stall_latency", 32'(lat), 32'd4);
    check("stall_result", 32'(bus.result), 32'd4);
    repeat (5) begin
      bus.data_in = 8'd77;
      tick();
      check("stall_done_ack", 32'(bus.ack), 32'd1);
      check("stall_done_result", 32'(bus.result), 32'd4);
    end
    end_txn();
    check("result_held_idle", 32'(bus.result), 32'd4);

    // req toggling during CALC is ignored.
    load_a(8'd9);
    load_b(8'd6);
    lat = 0;
    while (bus.ack !== 1'b1 && lat < 400) begin
      bus.req = ~bus.req;
      tick();
      lat++;
    end
    check("toggle_latency", 32'(lat), 32'd3);
    check("toggle_result", 32'(bus.result), 32'd3);
    end_txn();

    // Reset on the 100th CALC cycle of 255/1.
    load_a(8'd255);
    load_b(8'd1);
    repeat (99) tick();
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    check("midcalc_rst_ack", 32'(bus.ack), 32'd0);
    check("midcalc_rst_busy", 32'(bus.busy), 32'd0);
    check("midcalc_rst_result", 32'(bus.result), 32'd0);
`ifdef GCD_ITER_COUNT_EN
    check("midcalc_rst_iter", 32'(bus.iter_count), 32'd0);
`endif
    bus.req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    load_a(8'd4);
    load_b(8'd6);
    wait_done(lat, busy_n);
    check("post_reset_latency", 32'(lat), 32'd3);
    check("post_reset_result", 32'(bus.result), 32'd2);
    end_txn();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
